// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle control unit.
//   - state_t  : FSM state encoding (two distinct trap states carry the cause)
//   - class_t  : instruction classes produced by mc_class_decode
//   - ALU_*    : fixed ALU operation codes used by memory and branch classes
//   - REGDST_*/MEMTOREG_* : register-destination and write-back source selects
package multicycle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM      = 3'd4,
        ST_WB       = 3'd5,
        ST_TRAP_ILL = 3'd6,
        ST_TRAP_BUS = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_R_ALU = 4'd0,
        CL_R_JR  = 4'd1,
        CL_I_ALU = 4'd2,
        CL_LD    = 4'd3,
        CL_ST    = 4'd4,
        CL_BR    = 4'd5,
        CL_J     = 4'd6,
        CL_JAL   = 4'd7,
        CL_ILL   = 4'd8
    } class_t;

    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_LINK = 2'b10;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MEM = 2'b01;
    localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory-side bus of the multi-cycle control unit.
//   if_req / if_ack          : instruction fetch handshake
//   opcode / func            : instruction fields, valid while if_ack=1
//   dmem_req / dmem_we / dmem_ack : data memory handshake (dmem_we = store)
// master: the controller; slave: the memory side (or a testbench).
interface multicycle_ctrl_if;

    logic       if_req;
    logic       if_ack;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;

    modport master (
        output if_req, dmem_req, dmem_we,
        input  if_ack, opcode, func, dmem_ack
    );

    modport slave (
        input  if_req, dmem_req, dmem_we,
        output if_ack, opcode, func, dmem_ack
    );

endinterface

// File: rtl/mc_class_decode.sv
// Combinational instruction classifier.
//   op   in  6  opcode
//   func in  6  function field
//   cls  out    instruction class (class_t)
// Classes are selected by op[5:4]; R-type splits on func[3] (JR), memory on
// op[3] (store), control flow on op[1:0] with 10 reserved as illegal.
module mc_class_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output class_t     cls
);

    // Fields not needed for classification; the datapath uses them elsewhere.
    logic unused_fields;
    assign unused_fields = ^{op[2], func[5:4], func[2:0]};

    always_comb begin
        cls = CL_ILL;
        case (op[5:4])
            2'b00:   cls = func[3] ? CL_R_JR : CL_R_ALU;
            2'b01:   cls = CL_I_ALU;
            2'b10:   cls = op[3] ? CL_ST : CL_LD;
            default: begin
                case (op[1:0])
                    2'b00:   cls = CL_BR;
                    2'b01:   cls = CL_J;
                    2'b11:   cls = CL_JAL;
                    default: cls = CL_ILL;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memory,
// traps on illegal opcodes and memory-wait timeouts, counts retirements.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   run                 start request, sampled only in IDLE
//   bus                 memory-side handshake (multicycle_ctrl_if.master)
//   ir_write, pc_write  instruction-register latch / PC+4 strobes
//   aluop, alusrc       ALU operation and immediate-operand select
//   regdst, memtoreg    register destination / write-back source select
//   regwrite            register file write enable
//   branch, jump, pcsrc branch, jump, register-sourced target
//   illegal, bus_err    sticky trap indicators
//   retired             retired-instruction count (wraps)
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    multicycle_ctrl_if.master  bus,
    output logic               ir_write,
    output logic               pc_write,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alusrc,
    output logic [1:0]         regdst,
    output logic [1:0]         memtoreg,
    output logic               regwrite,
    output logic               branch,
    output logic               jump,
    output logic               pcsrc,
    output logic               illegal,
    output logic               bus_err,
    output logic [CNT_W-1:0]   retired
);

    // Wait counter only has to reach TIMEOUT-1.
    localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t            state, next_state;
    logic [5:0]        op_q, func_q;
    logic [WAIT_W-1:0] wait_cnt;
    class_t            cls;
    logic              timed_out;
    logic              retire;
    logic [3:0]        alu4;

    mc_class_decode u_class_decode (
        .op   (op_q),
        .func (func_q),
        .cls  (cls)
    );

    // Last acceptable request cycle without an ack ends the wait.
    assign timed_out = (TIMEOUT > 0) && (wait_cnt == WAIT_W'(TO_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (run) next_state = ST_FETCH;
            ST_FETCH: begin
                if (bus.if_ack)     next_state = ST_DECODE;
                else if (timed_out) next_state = ST_TRAP_BUS;
            end
            ST_DECODE: next_state = (cls == CL_ILL) ? ST_TRAP_ILL : ST_EXEC;
            ST_EXEC: begin
                case (cls)
                    CL_R_ALU, CL_I_ALU: next_state = ST_WB;
                    CL_LD, CL_ST:       next_state = ST_MEM;
                    default:            next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (bus.dmem_ack)   next_state = (cls == CL_ST) ? ST_FETCH : ST_WB;
                else if (timed_out) next_state = ST_TRAP_BUS;
            end
            ST_WB:     next_state = ST_FETCH;
            default:   next_state = state;  // traps are left only through reset
        endcase
    end

    // An instruction retires on whichever transition returns to FETCH.
    assign retire = (next_state == ST_FETCH) &&
                    (state == ST_EXEC || state == ST_MEM || state == ST_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            func_q   <= '0;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            if (state == ST_FETCH && bus.if_ack) begin
                op_q   <= bus.opcode;
                func_q <= bus.func;
            end
            // Staying in FETCH/MEM means no ack arrived this cycle.
            if (next_state != state)
                wait_cnt <= '0;
            else if (state == ST_FETCH || state == ST_MEM)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                retired <= retired + 1'b1;
        end
    end

    always_comb begin
        bus.if_req   = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        alu4         = 4'b0000;
        alusrc       = 1'b0;
        regdst       = REGDST_RT;
        memtoreg     = MEMTOREG_ALU;
        regwrite     = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        pcsrc        = 1'b0;
        illegal      = 1'b0;
        bus_err      = 1'b0;
        case (state)
            ST_FETCH: begin
                bus.if_req = 1'b1;
                // IR and PC strobes fire only on the accepting cycle.
                ir_write   = bus.if_ack;
                pc_write   = bus.if_ack;
            end
            ST_EXEC: begin
                case (cls)
                    CL_R_ALU: alu4 = {func_q[5], func_q[2:0]};
                    CL_I_ALU: begin
                        alu4   = {op_q[3], op_q[2:0]};
                        alusrc = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        alu4   = ALU_ADD;
                        alusrc = 1'b1;
                    end
                    CL_BR: begin
                        alu4   = ALU_SUB;
                        branch = 1'b1;
                    end
                    CL_J:     jump = 1'b1;
                    CL_JAL: begin
                        jump     = 1'b1;
                        regwrite = 1'b1;
                        regdst   = REGDST_LINK;
                        memtoreg = MEMTOREG_PC4;
                    end
                    CL_R_JR: begin
                        jump  = 1'b1;
                        pcsrc = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (cls == CL_ST);
                // Address computation stays stable while the request waits.
                alu4         = ALU_ADD;
                alusrc       = 1'b1;
            end
            ST_WB: begin
                regwrite = 1'b1;
                regdst   = (cls == CL_R_ALU) ? REGDST_RD : REGDST_RT;
                memtoreg = (cls == CL_LD) ? MEMTOREG_MEM : MEMTOREG_ALU;
            end
            ST_TRAP_ILL: illegal = 1'b1;
            ST_TRAP_BUS: bus_err = 1'b1;
            default: ;
        endcase
    end

    assign aluop = ALUOP_W'(alu4);

endmodule
